// File: rtl/spi_shift_engine_pkg.sv
// Shared constants for the SPI shift engine: FSM encodings, default sizing,
// and a helper for selector widths.
package spi_shift_engine_pkg;

  localparam int MAX_CHAR_DEF = 128;
  localparam int LEN_BITS_DEF = 7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Width of a selector over n items, never less than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_shift_engine_bit_pos.sv
// Maps a remaining-bit counter onto a data-register bit position.
// MSB first walks down from len_eff-1; LSB first walks up from 0.
module spi_shift_engine_bit_pos
  import spi_shift_engine_pkg::*;
#(
  parameter int LEN_BITS = LEN_BITS_DEF
) (
  input  logic [LEN_BITS:0]   cnt_i,
  input  logic [LEN_BITS:0]   len_eff_i,
  input  logic                lsb_i,
  output logic [LEN_BITS-1:0] pos_o
);

  logic [LEN_BITS:0] pos_full;
  logic              unused_pos_msb;

  // Position arithmetic is done one bit wider so len_eff == MAX_CHAR fits.
  always_comb begin
    pos_full = lsb_i ? (len_eff_i - cnt_i) : (cnt_i - (LEN_BITS + 1)'(1));
  end

  // Valid positions are always below MAX_CHAR, so the top bit is dropped.
  assign pos_o          = pos_full[LEN_BITS-1:0];
  assign unused_pos_msb = pos_full[LEN_BITS];

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: byte-enabled parallel load, serial TX on mosi and
// RX from miso driven by single-cycle sclk edge strobes, with done and abort.
module spi_shift_engine
  import spi_shift_engine_pkg::*;
#(
  parameter int MAX_CHAR  = MAX_CHAR_DEF,
  parameter int LEN_BITS  = LEN_BITS_DEF,
  parameter int NUM_WORDS = (MAX_CHAR + 31) / 32,
  localparam int WSEL_W   = sel_width(NUM_WORDS)
) (
  input  logic                wb_clk_in,
  input  logic                wb_rst,
  input  logic                pos_edge,
  input  logic                neg_edge,
  input  logic                tx_negedge,
  input  logic                rx_negedge,
  input  logic                lsb,
  input  logic [LEN_BITS-1:0] len,
  input  logic                go,
  input  logic                abort,
  input  logic                wr_en,
  input  logic [WSEL_W-1:0]   word_sel,
  input  logic [3:0]          byte_sel,
  input  logic [31:0]         p_in,
  input  logic                miso,
  output logic [MAX_CHAR-1:0] p_out,
  output logic                mosi,
  output logic                tip,
  output logic                last,
  output logic                done
);

  logic [1:0]          state_q, state_d;
  logic [LEN_BITS:0]   tx_cnt_q, tx_cnt_d;
  logic [LEN_BITS:0]   rx_cnt_q, rx_cnt_d;
  logic [LEN_BITS:0]   len_q, len_d;
  logic [MAX_CHAR-1:0] data_q, data_d;
  logic                mosi_q, mosi_d;

  logic [LEN_BITS:0]   len_eff_in;
  logic [LEN_BITS-1:0] tx_pos, rx_pos;
  logic                tx_stb, rx_stb, tx_act, rx_act;
  logic [MAX_CHAR-1:0] wr_mask, wr_data;

  // A zero length selects a full MAX_CHAR transfer.
  assign len_eff_in = (len == '0) ? (LEN_BITS + 1)'(MAX_CHAR) : {1'b0, len};

  assign tx_stb = tx_negedge ? neg_edge : pos_edge;
  assign rx_stb = rx_negedge ? neg_edge : pos_edge;
  // Abort wins over any strobe arriving in the same cycle.
  assign tx_act = (state_q == ST_SHIFT) && !abort && tx_stb && (tx_cnt_q != '0);
  assign rx_act = (state_q == ST_SHIFT) && !abort && rx_stb && (rx_cnt_q != '0);

  spi_shift_engine_bit_pos #(.LEN_BITS(LEN_BITS)) u_tx_pos (
    .cnt_i     (tx_cnt_q),
    .len_eff_i (len_q),
    .lsb_i     (lsb),
    .pos_o     (tx_pos)
  );

  spi_shift_engine_bit_pos #(.LEN_BITS(LEN_BITS)) u_rx_pos (
    .cnt_i     (rx_cnt_q),
    .len_eff_i (len_q),
    .lsb_i     (lsb),
    .pos_o     (rx_pos)
  );

  // Byte-write decode; bytes past MAX_CHAR and out-of-range words never match.
  always_comb begin
    wr_mask = '0;
    wr_data = '0;
    for (int b = 0; b < MAX_CHAR / 8; b++) begin
      wr_data[LEN_BITS'(b * 8) +: 8] = p_in[5'((b % 4) * 8) +: 8];
      if ((int'(word_sel) == (b / 4)) && byte_sel[2'(b % 4)]) begin
        wr_mask[LEN_BITS'(b * 8) +: 8] = 8'hFF;
      end
    end
  end

  // FSM, counters, shift data and mosi next-state.
  always_comb begin
    state_d  = state_q;
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    len_d    = len_q;
    data_d   = data_q;
    mosi_d   = mosi_q;

    case (state_q)
      ST_IDLE: begin
        if (go && !abort) begin
          state_d  = ST_SHIFT;
          tx_cnt_d = len_eff_in;
          rx_cnt_d = len_eff_in;
          len_d    = len_eff_in;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (rx_act && (rx_cnt_q == (LEN_BITS + 1)'(1))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Parallel writes only land while no transfer owns the register.
    if ((state_q != ST_SHIFT) && wr_en) begin
      data_d = (data_q & ~wr_mask) | (wr_data & wr_mask);
    end

    // TX samples data_q, so a same-cycle RX update is not seen by TX.
    if (tx_act) begin
      mosi_d   = data_q[tx_pos];
      tx_cnt_d = tx_cnt_q - (LEN_BITS + 1)'(1);
    end

    if (rx_act) begin
      data_d[rx_pos] = miso;
      rx_cnt_d       = rx_cnt_q - (LEN_BITS + 1)'(1);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge wb_clk_in or posedge wb_rst) begin
    if (wb_rst) begin
      state_q  <= ST_IDLE;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      len_q    <= '0;
      data_q   <= '0;
      mosi_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      len_q    <= len_d;
      data_q   <= data_d;
      mosi_q   <= mosi_d;
    end
  end

  assign p_out = data_q;
  assign mosi  = mosi_q;
  assign tip   = (state_q == ST_SHIFT);
  assign done  = (state_q == ST_DONE);
  assign last  = (state_q == ST_SHIFT) && (rx_cnt_q == (LEN_BITS + 1)'(1));

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine (MAX_CHAR=128): directed vector table, hand
// sequences for abort/reset/handshake corners, and randomized transfers
// compared cycle by cycle with a bit-index reference model.
module tb_spi_shift_engine;

  logic         clk;
  logic         rst;
  logic         pos_edge, neg_edge, tx_negedge, rx_negedge, lsb;
  logic [6:0]   len;
  logic         go, abort, wr_en;
  logic [1:0]   word_sel;
  logic [3:0]   byte_sel;
  logic [31:0]  p_in;
  logic         miso;
  logic [127:0] p_out;
  logic         mosi, tip, last, done;

  spi_shift_engine #(.MAX_CHAR(128), .LEN_BITS(7), .NUM_WORDS(4)) dut (
    .wb_clk_in  (clk),
    .wb_rst     (rst),
    .pos_edge   (pos_edge),
    .neg_edge   (neg_edge),
    .tx_negedge (tx_negedge),
    .rx_negedge (rx_negedge),
    .lsb        (lsb),
    .len        (len),
    .go         (go),
    .abort      (abort),
    .wr_en      (wr_en),
    .word_sel   (word_sel),
    .byte_sel   (byte_sel),
    .p_in       (p_in),
    .miso       (miso),
    .p_out      (p_out),
    .mosi       (mosi),
    .tip        (tip),
    .last       (last),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int done_seen = 0;
  logic [31:0] seq;
  logic loop, miso_val;

  // Reference model: a transfer is L bits; the k-th bit moved (TX or RX)
  // is register bit k (LSB first) or L-1-k (MSB first).
  logic         m_busy, m_done, m_mosi;
  logic [127:0] m_data;
  int           m_L, m_tx, m_rx;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_idx(input int k);
    return lsb ? k : (m_L - 1 - k);
  endfunction

  function automatic logic e_last();
    return m_busy && ((m_L - m_rx) == 1);
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_done = 1'b0; m_mosi = 1'b0; m_data = '0;
    m_L = 0; m_tx = 0; m_rx = 0;
  endtask

  task automatic model_step();
    logic         nb, nd, nmosi, txe, rxe;
    logic [127:0] ndata;
    int           ntx, nrx, nL;
    nb = m_busy; nd = 1'b0; nmosi = m_mosi; ndata = m_data;
    ntx = m_tx; nrx = m_rx; nL = m_L;
    if (!m_busy) begin
      if (wr_en) begin
        for (int b = 0; b < 4; b++) begin
          if (byte_sel[2'(b)]) ndata[7'(int'(word_sel) * 32 + b * 8) +: 8] = 8'(p_in >> (8 * b));
        end
      end
      if (!m_done && go && !abort) begin
        nb = 1'b1; nL = (len == '0) ? 128 : int'(len); ntx = 0; nrx = 0;
      end
    end else if (abort) begin
      nb = 1'b0;
    end else begin
      txe = tx_negedge ? neg_edge : pos_edge;
      rxe = rx_negedge ? neg_edge : pos_edge;
      if (txe && (m_tx < m_L)) begin
        nmosi = m_data[7'(m_idx(m_tx))];
        ntx++;
      end
      if (rxe && (m_rx < m_L)) begin
        ndata[7'(m_idx(m_rx))] = miso;
        nrx++;
        if (nrx == m_L) begin nb = 1'b0; nd = 1'b1; end
      end
    end
    m_busy = nb; m_done = nd; m_mosi = nmosi; m_data = ndata;
    m_tx = ntx; m_rx = nrx; m_L = nL;
  endtask

  // One clock: settle miso, advance the model, then compare after the edge.
  task automatic cycle();
    miso = loop ? m_mosi : miso_val;
    model_step();
    @(posedge clk);
    #1;
    chk("ctl{tip,done,last,mosi}", 128'({tip, done, last, mosi}),
        128'({m_busy, m_done, e_last(), m_mosi}));
    chk("p_out", p_out, m_data);
    if (done) done_seen++;
  endtask

  task automatic idle_inputs();
    pos_edge = 1'b0; neg_edge = 1'b0; go = 1'b0; abort = 1'b0; wr_en = 1'b0;
  endtask

  task automatic write_word(input logic [1:0] w, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; word_sel = w; p_in = d; byte_sel = be;
    cycle();
    wr_en = 1'b0;
  endtask

  // TX on the neg strobe, RX on the pos strobe; mosi captured after TX.
  task automatic xfer_bit();
    neg_edge = 1'b1; cycle(); neg_edge = 1'b0;
    seq = {seq[30:0], mosi};
    pos_edge = 1'b1; cycle(); pos_edge = 1'b0;
  endtask

  task automatic start(input logic [6:0] l, input logic order_lsb);
    len = l; lsb = order_lsb; tx_negedge = 1'b1; rx_negedge = 1'b0;
    go = 1'b1; cycle(); go = 1'b0;
    seq = '0; done_seen = 0;
  endtask

  typedef struct {
    logic [6:0]  len;
    logic        lsb;
    logic        loop;
    logic        miso;
    logic [31:0] load;
    logic [31:0] exp_p;
    logic [31:0] exp_mosi;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int guard, rx_issued, first_last, r;

    vecs[0] = '{7'd8,  1'b0, 1'b1, 1'b0, 32'h0000_00A5, 32'h0000_00A5, 32'h0000_00A5};
    vecs[1] = '{7'd8,  1'b1, 1'b1, 1'b0, 32'h0000_0035, 32'h0000_0035, 32'h0000_00AC};
    vecs[2] = '{7'd8,  1'b0, 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0000, 32'h0000_00FF};
    vecs[3] = '{7'd4,  1'b0, 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_00F0, 32'h0000_000F};
    vecs[4] = '{7'd16, 1'b1, 1'b1, 1'b0, 32'h0000_1234, 32'h0000_1234, 32'h0000_2C48};
    vecs[5] = '{7'd8,  1'b0, 1'b0, 1'b1, 32'h0000_0F00, 32'h0000_0FFF, 32'h0000_0000};
    vecs[6] = '{7'd12, 1'b0, 1'b1, 1'b0, 32'h0000_0ABC, 32'h0000_0ABC, 32'h0000_0ABC};

    idle_inputs();
    tx_negedge = 1'b1; rx_negedge = 1'b0; lsb = 1'b0; len = '0;
    word_sel = '0; byte_sel = '0; p_in = '0; miso = 1'b0;
    loop = 1'b0; miso_val = 1'b0; seq = '0;
    model_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #10;
    chk("reset ctl", 128'({tip, done, last, mosi}), 128'(0));
    chk("reset p_out", p_out, '0);
    @(posedge clk); #1 rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      write_word(2'd0, vecs[i].load, 4'hF);
      loop = vecs[i].loop; miso_val = vecs[i].miso;
      start(vecs[i].len, vecs[i].lsb);
      for (int k = 0; k < int'(vecs[i].len); k++) xfer_bit();
      cycle();
      chk($sformatf("vec%0d done pulses", i), 128'(done_seen), 128'(1));
      chk($sformatf("vec%0d tip", i), 128'(tip), 128'(0));
      chk($sformatf("vec%0d p_out", i), 128'(p_out[31:0]), 128'(vecs[i].exp_p));
      chk($sformatf("vec%0d mosi seq", i), 128'(seq), 128'(vecs[i].exp_mosi));
    end
    loop = 1'b0;

    // Abort after three received bits
    write_word(2'd0, 32'h0, 4'hF);
    miso_val = 1'b1;
    start(7'd8, 1'b0);
    repeat (3) xfer_bit();
    abort = 1'b1; cycle(); abort = 1'b0;
    chk("abort tip", 128'(tip), 128'(0));
    chk("abort partial", 128'(p_out[7:0]), 128'(8'hE0));
    repeat (3) cycle();
    chk("abort no done", 128'(done_seen), 128'(0));

    // Parallel write blocked during SHIFT, accepted after completion
    write_word(2'd1, 32'h0, 4'hF);
    miso_val = 1'b0;
    start(7'd8, 1'b0);
    repeat (2) xfer_bit();
    write_word(2'd1, 32'hFFFF_FFFF, 4'hF);
    chk("wr in shift", 128'(p_out[63:32]), 128'(0));
    repeat (6) xfer_bit();
    cycle();
    chk("wr xfer done", 128'(done_seen), 128'(1));
    write_word(2'd1, 32'hFFFF_FFFF, 4'hF);
    chk("wr after done", 128'(p_out[63:32]), 128'(32'hFFFF_FFFF));
    write_word(2'd2, 32'h0, 4'hF);
    write_word(2'd2, 32'h1122_3344, 4'b0101);
    chk("byte enables", 128'(p_out[95:64]), 128'(32'h0022_0044));

    // go and abort together in IDLE
    go = 1'b1; abort = 1'b1; cycle(); go = 1'b0; abort = 1'b0;
    chk("go+abort idle", 128'(tip), 128'(0));
    cycle();

    // go held through DONE: no restart until back in IDLE
    len = 7'd4; lsb = 1'b0; done_seen = 0;
    go = 1'b1; cycle();
    guard = 0;
    while (!done && guard < 100) begin
      xfer_bit();
      guard++;
    end
    chk("held-go done seen", 128'(done), 128'(1));
    chk("held-go tip in done", 128'(tip), 128'(0));
    cycle();
    chk("held-go idle gap", 128'(tip), 128'(0));
    cycle();
    chk("held-go restart", 128'(tip), 128'(1));
    go = 1'b0; abort = 1'b1; cycle(); abort = 1'b0;

    // Full 128-bit LSB-first transfer receiving all ones
    for (int w = 0; w < 4; w++) write_word(2'(w), 32'h0, 4'hF);
    miso_val = 1'b1;
    start(7'd0, 1'b1);
    rx_issued = 0; first_last = -1; guard = 0;
    while (done_seen == 0 && guard < 600) begin
      xfer_bit();
      rx_issued++;
      guard++;
      if (last && first_last < 0) first_last = rx_issued;
    end
    chk("full done", 128'(done_seen), 128'(1));
    chk("full rx count", 128'(rx_issued), 128'(128));
    chk("full last timing", 128'(first_last), 128'(127));
    chk("full p_out", p_out, {128{1'b1}});
    cycle();

    // Asynchronous reset mid-transfer
    write_word(2'd0, 32'h0000_00FF, 4'hF);
    miso_val = 1'b0;
    start(7'd8, 1'b0);
    repeat (2) xfer_bit();
    #3 rst = 1'b1;
    #1;
    chk("async rst ctl", 128'({tip, done, mosi}), 128'(0));
    chk("async rst p_out", p_out, '0);
    idle_inputs();
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    cycle();

    // Randomized transfers against the model
    for (int t = 0; t < 40; t++) begin
      idle_inputs();
      repeat ($urandom_range(1, 3)) begin
        write_word(2'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)));
      end
      len = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 24));
      lsb = 1'($urandom_range(0, 1));
      tx_negedge = 1'($urandom_range(0, 1));
      rx_negedge = 1'($urandom_range(0, 1));
      loop = 1'($urandom_range(0, 1));
      go = 1'b1; cycle(); go = 1'b0;
      guard = 0;
      while ((m_busy || m_done) && guard < 3000) begin
        r = $urandom_range(0, 2);
        pos_edge = (r == 1); neg_edge = (r == 2);
        miso_val = 1'($urandom_range(0, 1));
        go = ($urandom_range(0, 7) == 0);
        abort = ($urandom_range(0, 299) == 0);
        wr_en = ($urandom_range(0, 7) == 0);
        word_sel = 2'($urandom_range(0, 3));
        byte_sel = 4'($urandom_range(0, 15));
        p_in = $urandom;
        cycle();
        guard++;
      end
      if (guard >= 3000) chk("random xfer timeout", 128'(1), 128'(0));
      idle_inputs();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d of %0d checks)", n_err, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
